// File: rtl/nes_pkg.sv
// Shared NES pad definitions: frame width, button
// bit positions and the responder state encoding.
package nes_pkg;

    localparam int NES_BITS   = 8;

    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    typedef logic [1:0] nes_state_t;

    localparam nes_state_t IDLE  = 2'd0;
    localparam nes_state_t LOAD  = 2'd1;
    localparam nes_state_t SHIFT = 2'd2;
    localparam nes_state_t DONE  = 2'd3;

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer followed by a registered
// edge detector; level, rise and fall are mutually aligned.
module nes_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    // Synchronize the pin, then compare against the previous level.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            level <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~level;
            fall  <= ~chain[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/nes_pad_emulator.sv
// 4021-style NES pad responder: parallel-loads buttons
// while latched, shifts them out active-low on each pulse.
module nes_pad_emulator
    import nes_pkg::*;
#(
    parameter int   SYNC_STAGES    = 2,
    parameter int   TIMEOUT_CYCLES = 2_000_000,
    parameter logic TAIL_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NES_BITS-1:0] btns,
    input  logic                nes_latch,
    input  logic                nes_pulse,
    output logic                nes_data,
    output logic                frame_done,
    output logic                overrun,
    output logic                link_active,
    output logic [15:0]         frame_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic latch_s, latch_rise, latch_fall;
    logic pulse_s, pulse_rise, pulse_fall;
    logic unused_pulse;

    nes_sync_edge #(.STAGES(SYNC_STAGES)) u_latch (
        .clk   (clk),
        .reset (reset),
        .din   (nes_latch),
        .level (latch_s),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    nes_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse (
        .clk   (clk),
        .reset (reset),
        .din   (nes_pulse),
        .level (pulse_s),
        .rise  (pulse_rise),
        .fall  (pulse_fall)
    );

    assign unused_pulse = pulse_s ^ pulse_fall;

    nes_state_t          state, state_nxt;
    logic [NES_BITS-1:0] btns_q, sr, sr_nxt;
    logic [3:0]          bit_cnt, bit_nxt;
    logic                done_nxt, over_nxt;
    logic [15:0]         cnt_nxt;
    logic [TO_W-1:0]     to_cnt;
    logic                seen;

    // Next-state logic; a latch rise pre-empts everything else.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        bit_nxt   = bit_cnt;
        done_nxt  = 1'b0;
        over_nxt  = overrun;
        cnt_nxt   = frame_count;
        if (latch_rise) begin
            state_nxt = LOAD;
            sr_nxt    = ~btns_q;
            bit_nxt   = 4'd0;
            over_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                LOAD: begin
                    if (latch_fall) begin
                        state_nxt = SHIFT;
                        bit_nxt   = 4'd0;
                    end else if (latch_s) begin
                        sr_nxt = ~btns_q;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        sr_nxt = {TAIL_LEVEL, sr[NES_BITS-1:1]};
                        if (bit_cnt < 4'd8)
                            bit_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            done_nxt  = 1'b1;
                            cnt_nxt   = frame_count + 16'd1;
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (pulse_rise) begin
                        sr_nxt   = {TAIL_LEVEL, sr[NES_BITS-1:1]};
                        over_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame state, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            btns_q      <= '0;
            sr          <= '1;
            nes_data    <= 1'b1;
            bit_cnt     <= 4'd0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            state       <= state_nxt;
            btns_q      <= btns;
            sr          <= sr_nxt;
            nes_data    <= sr_nxt[0];
            bit_cnt     <= bit_nxt;
            frame_done  <= done_nxt;
            overrun     <= over_nxt;
            frame_count <= cnt_nxt;
        end
    end

    // Link watchdog: cycles since the last latch rise, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            seen   <= 1'b0;
        end else if (latch_rise) begin
            to_cnt <= '0;
            seen   <= 1'b1;
        end else if (to_cnt < TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign link_active = seen && (to_cnt < TO_MAX);

endmodule
